// File: rtl/packet_rx_if.sv
// packet_rx_if: AXI-Stream byte channel carrying received payload, tuser flags a bad frame on tlast.
interface packet_rx_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;
    logic       tready;
    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/packet_rx.sv
// packet_rx: RMII frame receiver with destination MAC filter, fixed-length AXI-Stream payload
// output and FCS check reported on the last beat.
module packet_rx #(
    parameter logic [47:0] LOCAL_MAC            = 48'h00_18_3e_04_b3_f2,
    parameter int          MII_WIDTH            = 2,
    parameter int          PACKET_PAYLOAD_BYTES = 64,
    parameter int          HEADER_BYTES         = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 crs_dv,
    input  logic [MII_WIDTH-1:0] rxd,
    packet_rx_if.master          m_axis,
    output logic                 rx_frame_ok,
    output logic                 rx_frame_err
);
    localparam int SPB   = 8 / MII_WIDTH;
    localparam int MAC_N = 48 / MII_WIDTH;
    localparam int HDR_N = HEADER_BYTES * SPB;
    localparam int DAT_N = PACKET_PAYLOAD_BYTES * SPB;
    localparam int FCS_N = 32 / MII_WIDTH;
    localparam int CW    = $clog2(HDR_N > DAT_N ? HDR_N : DAT_N) + 1;

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, DATA, FCS, DROP, WAIT_END} state_t;

    state_t               state, nstate;
    logic                 dv_q;
    logic [MII_WIDTH-1:0] rxd_q;
    logic [7:0]           sr, sr_n, hold, td;
    logic [47:0]          mac;
    logic [31:0]          crc, crc_n, crc_l, fcs, fcs_n;
    logic [CW-1:0]        cnt;
    logic                 held, ovf, pend, pend_user, fin, fin_user;
    logic                 load_byte, out_free, byte_done, tv, tl, tu;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [MII_WIDTH-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < MII_WIDTH; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
        return r;
    endfunction

    assign sr_n      = {rxd_q, sr[7:MII_WIDTH]};
    assign fcs_n     = {rxd_q, fcs[31:MII_WIDTH]};
    assign crc_n     = crc_step(crc, rxd_q);
    assign byte_done = (int'(cnt) % SPB) == SPB - 1;
    assign out_free  = !tv || m_axis.tready;
    assign load_byte = state == DATA && dv_q && byte_done && held;

    assign m_axis.tvalid = tv;
    assign m_axis.tdata  = td;
    assign m_axis.tlast  = tl;
    assign m_axis.tuser  = tu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nstate;
    end

    always_comb begin
        nstate   = state;
        fin      = 1'b0;
        fin_user = 1'b1;
        case (state)
            IDLE:     nstate = dv_q ? PREAMBLE : IDLE;
            PREAMBLE: nstate = !dv_q ? IDLE : (sr_n == 8'hD5 ? HEADER : PREAMBLE);
            HEADER: begin
                if (!dv_q) nstate = IDLE;
                else if (cnt == CW'(HDR_N - 1)) nstate = (mac == LOCAL_MAC || mac == '1) ? DATA : DROP;
            end
            DATA: begin
                if (!dv_q) begin
                    nstate = held ? WAIT_END : IDLE;
                    fin    = held;
                end else if (cnt == CW'(DAT_N - 1)) nstate = FCS;
            end
            FCS: begin
                if (!dv_q) begin
                    nstate = WAIT_END;
                    fin    = 1'b1;
                end else if (cnt == CW'(FCS_N - 1)) begin
                    nstate   = WAIT_END;
                    fin      = 1'b1;
                    fin_user = (fcs_n != ~crc_l) || ovf;
                end
            end
            DROP:     nstate = dv_q ? DROP : IDLE;
            // the next SFD is only sought once the previous tlast has left the block
            WAIT_END: nstate = (!dv_q && !pend && !(tv && tl)) ? IDLE : WAIT_END;
            default:  nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q         <= 1'b0;
            rxd_q        <= '0;
            sr           <= '0;
            hold         <= '0;
            mac          <= '0;
            crc          <= '0;
            crc_l        <= '0;
            fcs          <= '0;
            cnt          <= '0;
            held         <= 1'b0;
            ovf          <= 1'b0;
            pend         <= 1'b0;
            pend_user    <= 1'b0;
            tv           <= 1'b0;
            td           <= '0;
            tl           <= 1'b0;
            tu           <= 1'b0;
            rx_frame_ok  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            dv_q         <= crs_dv;
            rxd_q        <= rxd;
            sr           <= sr_n;
            cnt          <= state != nstate ? '0 : cnt + CW'(1);
            rx_frame_ok  <= 1'b0;
            rx_frame_err <= 1'b0;
            if (state == PREAMBLE) begin
                crc  <= '1;
                held <= 1'b0;
                ovf  <= 1'b0;
            end else if (state == HEADER || state == DATA) crc <= crc_n;
            if (state == HEADER && cnt < CW'(MAC_N)) mac <= {rxd_q, mac[47:MII_WIDTH]};
            if (state == DATA && cnt == CW'(DAT_N - 1)) crc_l <= crc_n;
            if (state == FCS) fcs <= fcs_n;
            if (state == DATA && dv_q && byte_done) begin
                hold <= sr_n;
                held <= 1'b1;
            end
            if (load_byte && !out_free) ovf <= 1'b1;
            if (fin) begin
                pend      <= 1'b1;
                pend_user <= fin_user;
            end
            // the last beat waits in hold for a free output slot; ordinary bytes are dropped instead
            if (pend && out_free) begin
                pend         <= 1'b0;
                tv           <= 1'b1;
                td           <= hold;
                tl           <= 1'b1;
                tu           <= pend_user;
                rx_frame_ok  <= !pend_user;
                rx_frame_err <= pend_user;
            end else if (load_byte && out_free) begin
                tv <= 1'b1;
                td <= hold;
                tl <= 1'b0;
                tu <= 1'b0;
            end else if (m_axis.tready) tv <= 1'b0;
        end
    end
endmodule

// File: tb/tb_packet_rx.sv
// tb_packet_rx: directed frames on RMII with hand-built FCS; checks payload stream and status pulses.
module tb_packet_rx;
    localparam logic [47:0] LOCAL = 48'h00_18_3e_04_b3_f2;
    localparam int FULL = 90;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       crs_dv = 1'b0;
    logic [1:0] rxd = 2'b00;
    logic       rx_frame_ok, rx_frame_err;

    packet_rx_if ax();

    packet_rx dut (
        .clk(clk),
        .rst_n(rst_n),
        .crs_dv(crs_dv),
        .rxd(rxd),
        .m_axis(ax),
        .rx_frame_ok(rx_frame_ok),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int cyc = 0, rdy_mode = 0, stall_at = 0;
    int ok_cnt = 0, err_cnt = 0, valid_cnt = 0;
    logic [9:0] beats[$];

    always @(negedge clk) begin
        if (ax.tvalid) valid_cnt++;
        if (ax.tvalid && ax.tready) beats.push_back({ax.tuser, ax.tlast, ax.tdata});
        if (rx_frame_ok) ok_cnt++;
        if (rx_frame_err) err_cnt++;
    end

    task automatic tick(input logic dv, input logic [1:0] d);
        @(posedge clk);
        #1;
        cyc++;
        crs_dv = dv;
        rxd = d;
        case (rdy_mode)
            0: ax.tready = 1'b1;
            1: ax.tready = (cyc % 3) != 0;
            2: ax.tready = !(cyc >= stall_at && cyc < stall_at + 12);
            default: ax.tready = 1'b0;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 2'b00);
    endtask

    task automatic clear_mon();
        beats.delete();
        ok_cnt = 0;
        err_cnt = 0;
        valid_cnt = 0;
    endtask

    // preamble, SFD, header (dest sent LSB-first), payload 0x00..0x3F, FCS; first nsend bytes go out
    task automatic send(input logic [47:0] dest, input int nsend, input logic flip);
        logic [7:0]  f[$];
        logic [7:0]  b;
        logic [31:0] c;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < 6; i++) f.push_back(dest[8*i +: 8]);
        for (int i = 0; i < 6; i++) f.push_back(8'hA0 + 8'(i));
        f.push_back(8'h08);
        f.push_back(8'h00);
        for (int i = 0; i < 64; i++) f.push_back(8'(i));
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < 86; i++) begin
            b = f[i];
            for (int k = 0; k < 8; k++) c = (c >> 1) ^ ((c[0] ^ b[k]) ? 32'hEDB8_8320 : 32'h0);
        end
        c = ~c ^ {31'd0, flip};
        for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
        for (int i = 0; i < nsend; i++) begin
            b = f[i];
            for (int k = 0; k < 4; k++) tick(1'b1, b[2*k +: 2]);
        end
    endtask

    function automatic int order_errs();
        int e = 0;
        foreach (beats[i]) begin
            if (beats[i][7:0] !== 8'(i)) e++;
            if (beats[i][8] !== (i == beats.size() - 1)) e++;
        end
        return e;
    endfunction

    function automatic int mono_errs();
        int e = 0;
        foreach (beats[i]) begin
            if (i > 0 && beats[i][7:0] <= beats[i-1][7:0]) e++;
            if (beats[i][8] !== (i == beats.size() - 1)) e++;
        end
        return e;
    endfunction

    function automatic logic [9:0] last_beat();
        return beats.size() > 0 ? beats[beats.size() - 1] : 10'hxxx;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        total++; if ({ax.tvalid, ax.tlast, ax.tuser, rx_frame_ok, rx_frame_err} !== 5'd0) $display("FAIL reset_ctrl got %b want 00000", {ax.tvalid, ax.tlast, ax.tuser, rx_frame_ok, rx_frame_err}); else passed++;
        total++; if (ax.tdata !== 8'h00) $display("FAIL reset_tdata got %h want 00", ax.tdata); else passed++;
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_good_unicast();
        clear_mon();
        send(LOCAL, FULL, 1'b0);
        idle(40);
        total++; if (beats.size() !== 64) $display("FAIL good_count got %0d want 64", beats.size()); else passed++;
        total++; if (order_errs() !== 0) $display("FAIL good_order got %0d errors want 0", order_errs()); else passed++;
        total++; if (last_beat() !== 10'h13F) $display("FAIL good_last got %h want 13f", last_beat()); else passed++;
        total++; if (ok_cnt !== 1) $display("FAIL good_ok got %0d want 1", ok_cnt); else passed++;
        total++; if (err_cnt !== 0) $display("FAIL good_err got %0d want 0", err_cnt); else passed++;
    endtask

    task automatic test_bad_fcs();
        clear_mon();
        send(LOCAL, FULL, 1'b1);
        idle(40);
        total++; if (beats.size() !== 64) $display("FAIL badfcs_count got %0d want 64", beats.size()); else passed++;
        total++; if (last_beat() !== 10'h33F) $display("FAIL badfcs_last got %h want 33f", last_beat()); else passed++;
        total++; if ({ok_cnt, err_cnt} !== {32'd0, 32'd1}) $display("FAIL badfcs_pulses got ok=%0d err=%0d want ok=0 err=1", ok_cnt, err_cnt); else passed++;
    endtask

    task automatic test_filter();
        clear_mon();
        send(48'h11_22_33_44_55_66, FULL, 1'b0);
        idle(40);
        total++; if (valid_cnt !== 0) $display("FAIL filter_valid got %0d cycles want 0", valid_cnt); else passed++;
        total++; if (ok_cnt + err_cnt !== 0) $display("FAIL filter_pulses got %0d want 0", ok_cnt + err_cnt); else passed++;
        clear_mon();
        send(48'hFF_FF_FF_FF_FF_FF, FULL, 1'b0);
        idle(40);
        total++; if (beats.size() !== 64) $display("FAIL bcast_count got %0d want 64", beats.size()); else passed++;
        total++; if (order_errs() !== 0) $display("FAIL bcast_order got %0d errors want 0", order_errs()); else passed++;
        total++; if (last_beat() !== 10'h13F) $display("FAIL bcast_last got %h want 13f", last_beat()); else passed++;
        total++; if (ok_cnt !== 1) $display("FAIL bcast_ok got %0d want 1", ok_cnt); else passed++;
    endtask

    task automatic test_abort();
        clear_mon();
        send(LOCAL, 8 + 14 + 10, 1'b0);
        idle(40);
        total++; if (beats.size() !== 10) $display("FAIL abort_count got %0d want 10", beats.size()); else passed++;
        total++; if (order_errs() !== 0) $display("FAIL abort_order got %0d errors want 0", order_errs()); else passed++;
        total++; if (last_beat() !== 10'h309) $display("FAIL abort_last got %h want 309", last_beat()); else passed++;
        total++; if ({ok_cnt, err_cnt} !== {32'd0, 32'd1}) $display("FAIL abort_pulses got ok=%0d err=%0d want ok=0 err=1", ok_cnt, err_cnt); else passed++;
        clear_mon();
        send(LOCAL, FULL, 1'b0);
        idle(40);
        total++; if (beats.size() !== 64 || order_errs() !== 0) $display("FAIL after_abort_stream got %0d beats %0d errors want 64 beats 0 errors", beats.size(), order_errs()); else passed++;
        total++; if ({last_beat(), ok_cnt, err_cnt} !== {10'h13F, 32'd1, 32'd0}) $display("FAIL after_abort_status got last=%h ok=%0d err=%0d want 13f 1 0", last_beat(), ok_cnt, err_cnt); else passed++;
    endtask

    task automatic test_overflow();
        clear_mon();
        rdy_mode = 2;
        stall_at = cyc + 32 + 56 + 40;
        send(LOCAL, FULL, 1'b0);
        idle(40);
        rdy_mode = 0;
        total++; if (!(beats.size() >= 61 && beats.size() <= 62)) $display("FAIL ovf_count got %0d want 61..62", beats.size()); else passed++;
        total++; if (mono_errs() !== 0) $display("FAIL ovf_order got %0d errors want 0", mono_errs()); else passed++;
        total++; if (last_beat() !== 10'h33F) $display("FAIL ovf_last got %h want 33f", last_beat()); else passed++;
        total++; if ({ok_cnt, err_cnt} !== {32'd0, 32'd1}) $display("FAIL ovf_pulses got ok=%0d err=%0d want ok=0 err=1", ok_cnt, err_cnt); else passed++;
    endtask

    task automatic test_random_ready();
        clear_mon();
        rdy_mode = 1;
        send(LOCAL, FULL, 1'b0);
        idle(40);
        rdy_mode = 0;
        total++; if (beats.size() !== 64) $display("FAIL rdy_count got %0d want 64", beats.size()); else passed++;
        total++; if (order_errs() !== 0) $display("FAIL rdy_order got %0d errors want 0", order_errs()); else passed++;
        total++; if ({last_beat(), ok_cnt, err_cnt} !== {10'h13F, 32'd1, 32'd0}) $display("FAIL rdy_status got last=%h ok=%0d err=%0d want 13f 1 0", last_beat(), ok_cnt, err_cnt); else passed++;
    endtask

    task automatic test_reset_mid_header();
        clear_mon();
        rdy_mode = 3;
        send(LOCAL, FULL, 1'b0);
        idle(10);
        total++; if (ax.tvalid !== 1'b1) $display("FAIL stuck_valid got %b want 1", ax.tvalid); else passed++;
        send(LOCAL, 13, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({ax.tvalid, ax.tlast, ax.tuser, rx_frame_ok, rx_frame_err, ax.tdata} !== 13'd0) $display("FAIL async_reset got %h want 0", {ax.tvalid, ax.tlast, ax.tuser, rx_frame_ok, rx_frame_err, ax.tdata}); else passed++;
        rdy_mode = 0;
        idle(3);
        rst_n = 1'b1;
        idle(3);
        clear_mon();
        send(LOCAL, 13, 1'b0);
        #2;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(40);
        total++; if ({valid_cnt, ok_cnt, err_cnt} !== 96'd0) $display("FAIL hdr_reset_quiet got valid=%0d ok=%0d err=%0d want 0 0 0", valid_cnt, ok_cnt, err_cnt); else passed++;
        clear_mon();
        send(LOCAL, FULL, 1'b0);
        idle(40);
        total++; if (beats.size() !== 64 || order_errs() !== 0) $display("FAIL post_reset_stream got %0d beats %0d errors want 64 beats 0 errors", beats.size(), order_errs()); else passed++;
        total++; if ({last_beat(), ok_cnt, err_cnt} !== {10'h13F, 32'd1, 32'd0}) $display("FAIL post_reset_status got last=%h ok=%0d err=%0d want 13f 1 0", last_beat(), ok_cnt, err_cnt); else passed++;
    endtask

    initial begin
        ax.tready = 1'b1;
        test_reset();
        test_good_unicast();
        test_bad_fcs();
        test_filter();
        test_abort();
        test_overflow();
        test_random_ready();
        test_reset_mid_header();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
